// File: rtl/iob_sequencer_pkg.sv
// Shared definitions for the KA10 I/O bus sequencer: request op codes,
// FSM state encodings and small op-classification helpers. The console
// front-end and benches import the same package.
package iob_sequencer_pkg;

   localparam logic [2:0] IOB_OP_CONO    = 3'd0;
   localparam logic [2:0] IOB_OP_DATAO   = 3'd1;
   localparam logic [2:0] IOB_OP_CONI    = 3'd2;
   localparam logic [2:0] IOB_OP_DATAI   = 3'd3;
   localparam logic [2:0] IOB_OP_IORESET = 3'd4;

   typedef enum logic [2:0] {
      IOB_ST_IDLE = 3'd0,
      IOB_ST_CLR  = 3'd1,
      IOB_ST_GAP  = 3'd2,
      IOB_ST_SET  = 3'd3,
      IOB_ST_RD   = 3'd4,
      IOB_ST_RST  = 3'd5,
      IOB_ST_DONE = 3'd6
   } iob_state_e;

   // CONO/DATAO put data on iob_in and use the clear/gap/set sequence.
   function automatic logic iob_op_is_write(input logic [2:0] op);
      return (op == IOB_OP_CONO) || (op == IOB_OP_DATAO);
   endfunction

   // CONI/DATAI use a single read strobe and return sampled data.
   function automatic logic iob_op_is_read(input logic [2:0] op);
      return (op == IOB_OP_CONI) || (op == IOB_OP_DATAI);
   endfunction

endpackage

// File: rtl/iob_pulse_timer.sv
// Loadable down-counter that times each sequencer state. Loading N-1 on
// state entry makes `last` true on the Nth cycle spent in that state.
module iob_pulse_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         last
);

   logic [W-1:0] cnt;

   // Reload on state entry, otherwise count down and park at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/iob_sequencer.sv
// Master-side sequencer for the KA10 I/O bus. Accepts one console request
// at a time and produces the timed clear/gap/set or read strobes, the bus
// reset pulse, and a one-cycle completion with the sampled device data.
// Bus vectors keep PDP-10 numbering by position: bit 35 here is bus bit 0.
module iob_sequencer
   import iob_sequencer_pkg::*;
#(
   parameter int CLR_CYCLES = 1,
   parameter int GAP_CYCLES = 7,
   parameter int SET_CYCLES = 1,
   parameter int RD_CYCLES  = 4,
   parameter int RST_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [6:0]  req_dev,
   input  logic [35:0] req_data,
   output logic        rsp_valid,
   output logic [35:0] rsp_data,
   output logic        iobus_iob_poweron,
   output logic        iobus_iob_reset,
   output logic        iobus_cono_clear,
   output logic        iobus_cono_set,
   output logic        iobus_datao_clear,
   output logic        iobus_datao_set,
   output logic        iobus_iob_fm_status,
   output logic        iobus_iob_fm_datai,
   output logic [6:0]  iobus_ios,
   output logic [35:0] iobus_iob_in,
   input  logic [35:0] iobus_iob_out
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYCLES = max2(max2(max2(CLR_CYCLES, GAP_CYCLES),
                                         max2(SET_CYCLES, RD_CYCLES)),
                                    RST_CYCLES);
   localparam int TW = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

   localparam logic [TW-1:0] CLR_LD = TW'(CLR_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] SET_LD = TW'(SET_CYCLES - 1);
   localparam logic [TW-1:0] RD_LD  = TW'(RD_CYCLES - 1);
   localparam logic [TW-1:0] RST_LD = TW'(RST_CYCLES - 1);

   iob_state_e    state, state_nxt;
   logic [2:0]    op_q, op_nxt;
   logic          accept;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_last;

   iob_pulse_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .last     (tmr_last)
   );

   assign req_ready = (state == IOB_ST_IDLE) && !reset;

   // Next-state, accept decode and timer reload on every state change.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      tmr_val   = '0;
      case (state)
         IOB_ST_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               case (req_op)
                  IOB_OP_CONO, IOB_OP_DATAO: state_nxt = IOB_ST_CLR;
                  IOB_OP_CONI, IOB_OP_DATAI: state_nxt = IOB_ST_RD;
                  IOB_OP_IORESET:            state_nxt = IOB_ST_RST;
                  default:                   state_nxt = IOB_ST_DONE;
               endcase
            end
         end
         IOB_ST_CLR:  if (tmr_last) state_nxt = IOB_ST_GAP;
         IOB_ST_GAP:  if (tmr_last) state_nxt = IOB_ST_SET;
         IOB_ST_SET:  if (tmr_last) state_nxt = IOB_ST_DONE;
         IOB_ST_RD:   if (tmr_last) state_nxt = IOB_ST_DONE;
         IOB_ST_RST:  if (tmr_last) state_nxt = IOB_ST_DONE;
         IOB_ST_DONE: state_nxt = IOB_ST_IDLE;
         default:     state_nxt = IOB_ST_IDLE;
      endcase
      tmr_load = (state_nxt != state);
      case (state_nxt)
         IOB_ST_CLR: tmr_val = CLR_LD;
         IOB_ST_GAP: tmr_val = GAP_LD;
         IOB_ST_SET: tmr_val = SET_LD;
         IOB_ST_RD:  tmr_val = RD_LD;
         IOB_ST_RST: tmr_val = RST_LD;
         default:    tmr_val = '0;
      endcase
      op_nxt = accept ? req_op : op_q;
   end

   // State and latched op; poweron rises on the first clock after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IOB_ST_IDLE;
         op_q              <= '0;
         iobus_iob_poweron <= 1'b0;
      end else begin
         state             <= state_nxt;
         op_q              <= op_nxt;
         iobus_iob_poweron <= 1'b1;
      end
   end

   // Strobes are decoded from the next state so each one is high exactly
   // while the FSM sits in its state, and clear/set never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iobus_cono_clear    <= 1'b0;
         iobus_cono_set      <= 1'b0;
         iobus_datao_clear   <= 1'b0;
         iobus_datao_set     <= 1'b0;
         iobus_iob_fm_status <= 1'b0;
         iobus_iob_fm_datai  <= 1'b0;
         iobus_iob_reset     <= 1'b0;
         rsp_valid           <= 1'b0;
      end else begin
         iobus_cono_clear    <= (state_nxt == IOB_ST_CLR) && (op_nxt == IOB_OP_CONO);
         iobus_cono_set      <= (state_nxt == IOB_ST_SET) && (op_nxt == IOB_OP_CONO);
         iobus_datao_clear   <= (state_nxt == IOB_ST_CLR) && (op_nxt == IOB_OP_DATAO);
         iobus_datao_set     <= (state_nxt == IOB_ST_SET) && (op_nxt == IOB_OP_DATAO);
         iobus_iob_fm_status <= (state_nxt == IOB_ST_RD)  && (op_nxt == IOB_OP_CONI);
         iobus_iob_fm_datai  <= (state_nxt == IOB_ST_RD)  && (op_nxt == IOB_OP_DATAI);
         iobus_iob_reset     <= (state_nxt == IOB_ST_RST);
         rsp_valid           <= (state_nxt == IOB_ST_DONE);
      end
   end

   // Device select and write data are held from accept until DONE ends;
   // the response is sampled on the last read cycle or cleared otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iobus_ios    <= '0;
         iobus_iob_in <= '0;
         rsp_data     <= '0;
      end else begin
         if (accept) begin
            iobus_ios    <= (req_op == IOB_OP_IORESET) ? 7'd0 : req_dev;
            iobus_iob_in <= iob_op_is_write(req_op) ? req_data : 36'd0;
         end else if (state == IOB_ST_DONE) begin
            iobus_ios    <= '0;
            iobus_iob_in <= '0;
         end
         if ((state_nxt == IOB_ST_DONE) && (state != IOB_ST_DONE)) begin
            rsp_data <= (state == IOB_ST_RD && iob_op_is_read(op_q)) ? iobus_iob_out : 36'd0;
         end
      end
   end

endmodule
